// File: rtl/pu_or1k_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pu_or1k_wb_pkg
//  Purpose  : Shared constants and enumerations for the Wishbone initiator
//             (cycle-type codes, burst type, completion status, FSM states).
//  Revision : 1.0 - initial release
// ============================================================================
package pu_or1k_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        STAT_OK      = 2'd0,
        STAT_BUS_ERR = 2'd1,
        STAT_TIMEOUT = 2'd2
    } wb_status_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/pu_or1k_wb_master_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : pu_or1k_wb_watchdog
//  Purpose  : Counts cycles a strobe is left unanswered and flags expiry
//             once TIMEOUT cycles have elapsed. TIMEOUT = 0 disables it.
//  Revision : 1.0 - initial release
// ============================================================================
module pu_or1k_wb_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic stb_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = clk ^ rst_n ^ clr_i ^ stb_i;
            assign expired_o     = 1'b0;
        end else begin : g_enabled
            localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            // Count stalled strobe cycles, saturating at the limit
            always_comb begin
                count_d = count_q;
                if (clr_i || !stb_i) begin
                    count_d = '0;
                end else if (count_q != LIMIT) begin
                    count_d = count_q + 1'b1;
                end
            end

            // Counter register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            // A response arriving in the expiry cycle still wins
            assign expired_o = stb_i && !clr_i && (count_q == LIMIT);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pu_or1k_wb_master.sv
`default_nettype none
// ============================================================================
//  Module   : pu_or1k_wb_master
//  Purpose  : Wishbone B3 initiator turning a command / write-data stream
//             into single and incrementing-burst cycles, with per-command
//             completion status (OK, bus error, watchdog timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module pu_or1k_wb_master
    import pu_or1k_wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [3:0]    cmd_len_i,
    input  logic [3:0]    cmd_sel_i,
    input  logic          wdat_valid_i,
    output logic          wdat_ready_o,
    input  logic [DW-1:0] wdat_i,
    output logic          rdat_valid_o,
    output logic [DW-1:0] rdat_o,
    output logic          resp_valid_o,
    input  logic          resp_ready_i,
    output logic [1:0]    resp_status_o,
    output logic [4:0]    resp_beats_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    wb_state_e     state_q,       state_d;
    logic          cyc_q,         cyc_d;
    logic          stb_q,         stb_d;
    logic          we_q,          we_d;
    logic [AW-1:0] adr_q,         adr_d;
    logic [DW-1:0] dat_q,         dat_d;
    logic [3:0]    sel_q,         sel_d;
    logic [2:0]    cti_q,         cti_d;
    logic [3:0]    len_q,         len_d;
    logic [4:0]    beat_cnt_q,    beat_cnt_d;
    logic          cmd_ready_q,   cmd_ready_d;
    logic          rdat_valid_q,  rdat_valid_d;
    logic [DW-1:0] rdat_q,        rdat_d;
    logic          resp_valid_q,  resp_valid_d;
    wb_status_e    resp_status_q, resp_status_d;
    logic [4:0]    resp_beats_q,  resp_beats_d;

    logic          last;
    logic          ack_hit;
    logic          err_hit;
    logic          to_hit;
    logic          wd_expired;
    logic          wdat_take;
    logic          fin;
    wb_status_e    fin_status;
    logic          unused_adr_bits;

    // Word-aligned addressing: the two low address bits are discarded
    assign unused_adr_bits = ^cmd_adr_i[1:0];

    // Beat qualification; err takes priority over a simultaneous ack
    assign last    = (beat_cnt_q == {1'b0, len_q});
    assign err_hit = stb_q && wb_err_i;
    assign ack_hit = stb_q && wb_ack_i && !wb_err_i;
    assign to_hit  = stb_q && wd_expired;

    // Take the next write word when no beat is pending, or the pending one
    // is finishing and more beats follow
    assign wdat_ready_o = (state_q == WR) && !err_hit && !to_hit &&
                          (!stb_q || (ack_hit && !last));
    assign wdat_take    = wdat_valid_i && wdat_ready_o;

    pu_or1k_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .clr_i     ((state_q == IDLE) || wb_ack_i || wb_err_i),
        .stb_i     (stb_q),
        .expired_o (wd_expired)
    );

    // Next-state and next-output computation for the command sequencer
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        we_d          = we_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        sel_d         = sel_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        rdat_valid_d  = 1'b0;
        rdat_d        = rdat_q;
        resp_valid_d  = resp_valid_q;
        resp_status_d = resp_status_q;
        resp_beats_d  = resp_beats_q;
        fin           = 1'b0;
        fin_status    = STAT_OK;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d       = cmd_we_i;
                    adr_d      = {cmd_adr_i[AW-1:2], 2'b00};
                    sel_d      = cmd_sel_i;
                    len_d      = cmd_len_i;
                    beat_cnt_d = 5'd0;
                    cyc_d      = 1'b1;
                    // Writes wait for their first data word before strobing
                    stb_d      = !cmd_we_i;
                    if (cmd_we_i) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end

            WR: begin
                if (err_hit) begin
                    fin        = 1'b1;
                    fin_status = STAT_BUS_ERR;
                end else if (to_hit) begin
                    fin        = 1'b1;
                    fin_status = STAT_TIMEOUT;
                end else begin
                    if (ack_hit) begin
                        beat_cnt_d = beat_cnt_q + 5'd1;
                        adr_d      = adr_q + AW'(4);
                        if (last) begin
                            fin = 1'b1;
                        end else begin
                            stb_d = 1'b0;
                        end
                    end
                    if (wdat_take) begin
                        dat_d = wdat_i;
                        stb_d = 1'b1;
                    end
                end
            end

            RD: begin
                if (err_hit) begin
                    fin        = 1'b1;
                    fin_status = STAT_BUS_ERR;
                end else if (to_hit) begin
                    fin        = 1'b1;
                    fin_status = STAT_TIMEOUT;
                end else if (ack_hit) begin
                    rdat_valid_d = 1'b1;
                    rdat_d       = wb_dat_i;
                    beat_cnt_d   = beat_cnt_q + 5'd1;
                    adr_d        = adr_q + AW'(4);
                    fin          = last;
                end
            end

            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d  = 1'b0;
                    resp_status_d = STAT_OK;
                    resp_beats_d  = 5'd0;
                    state_d       = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Completion (normal or aborted) closes the cycle and posts status
        if (fin) begin
            cyc_d         = 1'b0;
            stb_d         = 1'b0;
            state_d       = RESP;
            resp_valid_d  = 1'b1;
            resp_status_d = fin_status;
            resp_beats_d  = beat_cnt_d;
        end

        cmd_ready_d = (state_d == IDLE);
        cti_d       = !cyc_d ? CTI_CLASSIC :
                      (beat_cnt_d == {1'b0, len_d}) ? CTI_EOB : CTI_INCR;
    end

    // State and registered-output update; reset drops the bus immediately
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q       <= IDLE;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            dat_q         <= '0;
            sel_q         <= 4'd0;
            cti_q         <= CTI_CLASSIC;
            len_q         <= 4'd0;
            beat_cnt_q    <= 5'd0;
            cmd_ready_q   <= 1'b0;
            rdat_valid_q  <= 1'b0;
            rdat_q        <= '0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= STAT_OK;
            resp_beats_q  <= 5'd0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            sel_q         <= sel_d;
            cti_q         <= cti_d;
            len_q         <= len_d;
            beat_cnt_q    <= beat_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rdat_valid_q  <= rdat_valid_d;
            rdat_q        <= rdat_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            resp_beats_q  <= resp_beats_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rdat_valid_o  = rdat_valid_q;
    assign rdat_o        = rdat_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_status_o = resp_status_q;
    assign resp_beats_o  = resp_beats_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_sel_o      = sel_q;
    assign wb_we_o       = we_q;
    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = stb_q;
    assign wb_cti_o      = cti_q;
    assign wb_bte_o      = BTE_LINEAR;

endmodule
`default_nettype wire

// File: tb/tb_pu_or1k_wb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pu_or1k_wb_master
//  Purpose  : Directed self-checking bench for the Wishbone initiator with a
//             behavioural memory responder and expected-result queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pu_or1k_wb_master;
    import pu_or1k_wb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [3:0]    cmd_len_i, cmd_sel_i;
    logic          wdat_valid_i, wdat_ready_o;
    logic [DW-1:0] wdat_i;
    logic          rdat_valid_o;
    logic [DW-1:0] rdat_o;
    logic          resp_valid_o, resp_ready_i;
    logic [1:0]    resp_status_o;
    logic [4:0]    resp_beats_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o, wb_dat_i;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;

    always #5 clk = ~clk;

    pu_or1k_wb_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i), .cmd_sel_i(cmd_sel_i),
        .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
        .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_status_o(resp_status_o), .resp_beats_o(resp_beats_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic        we;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        int          gap;
    } wbeat_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem [0:1023];
    logic [31:0] exp_rd[$];
    logic [6:0]  exp_resp[$];
    beat_t       trace[$];
    wbeat_t      wq[$];
    int          bidx = 0;
    int          ack_limit = 1000;
    int          err_beat = -1;
    int          stb_cycles = 0;
    int          rd_cnt = 0;
    int          gap_cycles = 0;
    logic [31:0] gap_adr = '0;
    int          gap_cnt = 0;
    bit          wtake = 1'b0;
    logic [9:0]  ridx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: reacts one step after each rising edge
    always @(posedge clk) begin
        #1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (rst_n && wb_cyc_o && wb_stb_o) begin
            stb_cycles++;
            ridx = wb_adr_o[11:2];
            if (bidx == err_beat) begin
                wb_err_i = 1'b1;
                bidx++;
            end else if (bidx < ack_limit) begin
                wb_ack_i = 1'b1;
                trace.push_back({wb_adr_o, wb_cti_o, wb_we_o});
                if (wb_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (wb_sel_o[b]) mem[ridx][8*b +: 8] = wb_dat_o[8*b +: 8];
                end else begin
                    wb_dat_i = mem[ridx];
                end
                bidx++;
            end
        end
    end

    // Write-data source with per-word idle gaps
    always @(negedge clk) wtake = wdat_valid_i && wdat_ready_o && rst_n;

    always @(posedge clk) begin
        #1;
        if (wtake) begin
            void'(wq.pop_front());
            if (wq.size() != 0) gap_cnt = wq[0].gap;
        end
        if (gap_cnt > 0) begin
            wdat_valid_i = 1'b0;
            gap_cnt--;
        end else if (wq.size() != 0) begin
            wdat_valid_i = 1'b1;
            wdat_i       = wq[0].data;
        end else begin
            wdat_valid_i = 1'b0;
        end
    end

    // Read-data scoreboard and wait-state observer
    always @(negedge clk) begin
        if (rst_n && rdat_valid_o) begin
            rd_cnt++;
            if (exp_rd.size() == 0) chk("rdat_extra", exp_rd.size(), 1);
            else                    chk("rdat", rdat_o, exp_rd.pop_front());
        end
        if (rst_n && wb_cyc_o && !wb_stb_o) begin
            gap_cycles++;
            gap_adr = wb_adr_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic issue(input bit we, input logic [31:0] adr, input logic [3:0] len,
                         input logic [3:0] sel, input bit want_resp,
                         input wb_status_e st, input logic [4:0] beats);
        int n = 0;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready_o, 1);
        bidx = 0;
        if (want_resp) exp_resp.push_back({st, beats});
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_len_i   = len;
        cmd_sel_i   = sel;
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_resp();
        int         n = 0;
        logic [6:0] e;
        while (!resp_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", resp_valid_o, 1);
        e = (exp_resp.size() != 0) ? exp_resp.pop_front() : 7'h7F;
        chk("resp_status", resp_status_o, e[6:5]);
        chk("resp_beats", resp_beats_o, e[4:0]);
        chk("resp_cyc", wb_cyc_o, 0);
        @(negedge clk);
        chk("resp_hold", {resp_valid_o, resp_status_o, resp_beats_o}, {1'b1, e});
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        chk("resp_drop", resp_valid_o, 0);
    endtask

    initial begin
        cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = '0; cmd_len_i = '0; cmd_sel_i = '0;
        wdat_valid_i = 0; wdat_i = '0; resp_ready_i = 0;
        wb_dat_i = '0; wb_ack_i = 0; wb_err_i = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | i;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", {wb_cyc_o, wb_stb_o, wb_we_o, cmd_ready_o, resp_valid_o,
                         rdat_valid_o, wdat_ready_o, wb_cti_o, wb_bte_o}, 0);
        chk("rst_adr", wb_adr_o, 0);
        rst_n = 1'b1;
        chk("rdy_at_release", cmd_ready_o, 0);
        @(negedge clk);
        chk("rdy_after_release", cmd_ready_o, 1);

        // Single write then readback
        trace.delete();
        wq.push_back('{data: 32'hDEADBEEF, gap: 0});
        issue(1, 32'h100, 4'd0, 4'hF, 1, STAT_OK, 5'd1);
        chk("busy_not_ready", cmd_ready_o, 0);
        wait_resp();
        chk("t1_nbeats", trace.size(), 1);
        chk("t1_beat", trace[0], {32'h100, CTI_EOB, 1'b1});
        exp_rd.push_back(32'hDEADBEEF);
        issue(0, 32'h103, 4'd0, 4'hF, 1, STAT_OK, 5'd1);
        wait_resp();

        // 8-beat incrementing read
        for (int i = 0; i < 8; i++) begin
            mem[32'h80 + i] = 32'(i * 32'h11);
            exp_rd.push_back(32'(i * 32'h11));
        end
        trace.delete();
        rd_cnt = 0;
        issue(0, 32'h200, 4'd7, 4'hF, 1, STAT_OK, 5'd8);
        wait_resp();
        chk("t2_nbeats", trace.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("t2_beat", trace[i], {32'h200 + 32'(4 * i), (i == 7) ? CTI_EOB : CTI_INCR, 1'b0});
        chk("t2_rdcnt", rd_cnt, 8);

        // 4-beat write with a 3-cycle data gap after the second word
        wq.push_back('{data: 32'h1111_0000, gap: 0});
        wq.push_back('{data: 32'h2222_0001, gap: 0});
        wq.push_back('{data: 32'h3333_0002, gap: 3});
        wq.push_back('{data: 32'h4444_0003, gap: 0});
        gap_cycles = 0;
        trace.delete();
        issue(1, 32'h300, 4'd3, 4'hF, 1, STAT_OK, 5'd4);
        wait_resp();
        chk("t3_wait_cycles", gap_cycles, 4);
        chk("t3_gap_adr", gap_adr, 32'h308);
        chk("t3_last_beat", trace[3], {32'h30C, CTI_EOB, 1'b1});
        chk("t3_mem0", mem[32'hC0], 32'h1111_0000);
        chk("t3_mem1", mem[32'hC1], 32'h2222_0001);
        chk("t3_mem2", mem[32'hC2], 32'h3333_0002);
        chk("t3_mem3", mem[32'hC3], 32'h4444_0003);

        // Bus error on the third beat of a 6-beat read
        exp_rd.push_back(32'hA5A5_0100);
        exp_rd.push_back(32'hA5A5_0101);
        err_beat   = 2;
        rd_cnt     = 0;
        stb_cycles = 0;
        issue(0, 32'h400, 4'd5, 4'hF, 1, STAT_BUS_ERR, 5'd2);
        wait_resp();
        chk("t4_rdcnt", rd_cnt, 2);
        chk("t4_stb_cycles", stb_cycles, 3);
        err_beat = -1;

        // Watchdog: responder never answers
        ack_limit  = 0;
        stb_cycles = 0;
        issue(0, 32'h500, 4'd3, 4'hF, 1, STAT_TIMEOUT, 5'd0);
        wait_resp();
        chk("t5_stb_cycles", stb_cycles, 16);

        // Address wrap, then reset in the middle of the burst
        ack_limit = 1;
        exp_rd.push_back(32'hA5A5_03FF);
        issue(0, 32'hFFFF_FFFC, 4'd1, 4'hF, 0, STAT_OK, 5'd0);
        repeat (3) @(negedge clk);
        chk("t6_wrap_adr", wb_adr_o, 32'h0);
        chk("t6_wrap_bus", {wb_cyc_o, wb_stb_o, wb_cti_o}, {1'b1, 1'b1, CTI_EOB});
        #2 rst_n = 1'b0;
        #1 chk("t6_async_drop", {wb_cyc_o, wb_stb_o}, 2'b00);
        ack_limit = 1000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            @(negedge clk);
            chk("t6_rdy_after", cmd_ready_o, 1);
            repeat (5) begin
                if (resp_valid_o) seen++;
                @(negedge clk);
            end
            chk("t6_no_resp", seen, 0);
        end

        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("resp_queue_empty", exp_resp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
